// File: rtl/hex_fb_if.sv
// Font ROM / framebuffer port bundle for the hex painter.
// The painter side is the master; the surrounding system is the slave.
interface hex_fb_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                refresh;
    logic [11:0]         font_addr;
    logic [7:0]          font_data;
    logic                fb_we;
    logic [15:0]         fb_waddr;
    logic [7:0]          fb_wdata;
    logic                busy;
    logic                done;

    modport master (
        input  value, refresh, font_data,
        output font_addr, fb_we, fb_waddr, fb_wdata, busy, done
    );

    modport slave (
        output value, refresh, font_data,
        input  font_addr, fb_we, fb_waddr, fb_wdata, busy, done
    );
endinterface

// File: rtl/hex_fb_painter.sv
// Change-driven painter: snapshots a hex value and sweeps its glyphs
// from the font ROM into the framebuffer, one byte per clock.
module hex_fb_painter #(
    parameter int DIGITS       = 4,
    parameter int ROW_BYTES    = 40,
    parameter int DIGIT_STRIDE = 2,
    parameter int BASE_ADDR    = 0,
    parameter int GLYPH_BASE   = 0
) (
    input  logic     CLOCK_50,
    input  logic     rst_n,
    hex_fb_if.master bus
);
    localparam int VW = 4 * DIGITS;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
    localparam logic [15:0]   ROW_STEP   = 16'(ROW_BYTES);
    localparam logic [15:0]   COL_STEP   = 16'(DIGIT_STRIDE);
    localparam logic [15:0]   BASE       = 16'(BASE_ADDR);
    localparam logic [11:0]   GBASE      = 12'(GLYPH_BASE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] snap_q, snap_d;
    logic          pending_q, pending_d;
    logic [DW-1:0] digit_q, digit_d;
    logic [3:0]    row_q, row_d;
    logic [15:0]   row_acc_q, row_acc_d;
    logic [15:0]   col_acc_q, col_acc_d;
    logic          we_q, we_d;
    logic [15:0]   waddr_q, waddr_d;
    logic [3:0]    nib;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            pending_q <= 1'b1;
            digit_q   <= '0;
            row_q     <= '0;
            row_acc_q <= '0;
            col_acc_q <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            digit_q   <= digit_d;
            row_q     <= row_d;
            row_acc_q <= row_acc_d;
            col_acc_q <= col_acc_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        pending_d = pending_q;
        digit_d   = digit_q;
        row_d     = row_q;
        row_acc_d = row_acc_q;
        col_acc_d = col_acc_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        unique case (state_q)
            S_IDLE: begin
                if (pending_q || bus.refresh || (bus.value != snap_q)) begin
                    snap_d    = bus.value;
                    pending_d = 1'b0;
                    digit_d   = '0;
                    row_d     = '0;
                    row_acc_d = '0;
                    col_acc_d = BASE;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                pending_d = pending_q | bus.refresh;
                // Address is registered so it lands with the ROM's data.
                we_d      = 1'b1;
                waddr_d   = col_acc_q + row_acc_q;
                row_d     = row_q + 4'd1;
                if (row_q == 4'hF) begin
                    row_acc_d = '0;
                    col_acc_d = col_acc_q + COL_STEP;
                    if (digit_q == LAST_DIGIT) begin
                        digit_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                end else begin
                    row_acc_d = row_acc_q + ROW_STEP;
                end
            end
            S_DRAIN: begin
                pending_d = pending_q | bus.refresh;
                state_d   = S_DONE;
            end
            S_DONE: begin
                pending_d = pending_q | bus.refresh;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_q == DW'(i)) nib = snap_q[4*(DIGITS-1-i) +: 4];
        end
    end

    assign bus.font_addr = GBASE + {4'b0, nib, row_q};
    assign bus.fb_we     = we_q;
    assign bus.fb_waddr  = waddr_q;
    assign bus.fb_wdata  = we_q ? bus.font_data : 8'h00;
    assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_hex_fb_painter.sv
// Scoreboard bench for hex_fb_painter: stimulus pushes expected writes,
// a negedge monitor pops and compares every framebuffer write.
module tb_hex_fb_painter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   nwr = 0;
  logic bprev = 1'b0;
  logic [23:0] exp_q[$];

  hex_fb_if #(.DIGITS(4)) bus();

  hex_fb_painter dut (
    .CLOCK_50(clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.font_data <= bus.font_addr[7:0];

  always @(posedge clk) begin
    #1;
    if (bus.busy && !bprev) cyc = 0;
    else cyc++;
    bprev = bus.busy;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_sweep(input logic [15:0] v);
    logic [3:0] nb;
    for (int d = 0; d < 4; d++)
      for (int r = 0; r < 16; r++) begin
        nb = v[4*(3-d) +: 4];
        exp_q.push_back({16'(d*2 + r*40), nb, 4'(r)});
      end
  endtask

  always @(negedge clk) begin
    logic [23:0] e;
    if (!rst_n) nwr = 0;
    if (bus.fb_we) begin
      nwr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {8'h0, bus.fb_waddr, bus.fb_wdata}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("write", {8'h0, bus.fb_waddr, bus.fb_wdata}, {8'h0, e});
      end
    end
    if (bus.done) begin
      chk("done_cycle", cyc, 65);
      chk("sweep_writes", nwr, 64);
      nwr = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 300; i++) begin
      step();
      if (cyc == n && (bus.busy || bus.done)) return;
    end
    chk("timeout_cyc", 1, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.done) return;
    end
    chk("timeout_done", 1, 0);
  endtask

  task automatic pulse_refresh();
    bus.refresh = 1'b1;
    step();
    bus.refresh = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int viol;
    bus.value   = 16'h0000;
    bus.refresh = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_we", bus.fb_we, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_faddr", bus.font_addr, 0);
    chk("rst_waddr", bus.fb_waddr, 0);
    chk("rst_wdata", bus.fb_wdata, 0);
    push_sweep(16'h0000);
    rst_n = 1'b1;
    wait_cyc(0);
    chk("s0_faddr0", bus.font_addr, 12'h000);
    wait_cyc(1);
    chk("s0_first_we", bus.fb_we, 1);
    chk("s0_first_waddr", bus.fb_waddr, 0);
    chk("s0_first_wdata", bus.fb_wdata, 0);
    wait_cyc(2);
    chk("s0_row1_waddr", bus.fb_waddr, 40);
    wait_cyc(64);
    chk("s0_last_waddr", bus.fb_waddr, 606);
    wait_cyc(65);
    chk("s0_done", bus.done, 1);
    chk("s0_busy_off", bus.busy, 0);
    chk("s0_we_off", bus.fb_we, 0);
    repeat (4) step();

    bus.value = 16'h1A3F;
    push_sweep(16'h1A3F);
    wait_cyc(0);
    chk("v_d0_faddr", bus.font_addr, 12'h010);
    wait_cyc(16);
    chk("v_d1_faddr", bus.font_addr, 12'h0A0);
    wait_cyc(63);
    chk("v_d3r15_faddr", bus.font_addr, 12'h0FF);
    wait_cyc(64);
    chk("v_last_waddr", bus.fb_waddr, 606);
    chk("v_last_wdata", bus.fb_wdata, 8'hFF);
    wait_done();
    repeat (4) step();

    bus.value = 16'h1234;
    push_sweep(16'h1234);
    wait_cyc(20);
    bus.value = 16'h5678;
    push_sweep(16'h5678);
    wait_cyc(65);
    step();
    chk("chg_c66_busy", bus.busy, 0);
    step();
    chk("chg_c67_busy", bus.busy, 1);
    chk("chg_c67_faddr", bus.font_addr, 12'h050);
    wait_done();
    repeat (4) step();

    push_sweep(16'h5678);
    pulse_refresh();
    wait_cyc(10);
    push_sweep(16'h5678);
    pulse_refresh();
    step();
    pulse_refresh();
    step();
    pulse_refresh();
    wait_done();
    wait_done();
    repeat (20) step();
    chk("refresh_drained", exp_q.size(), 0);

    push_sweep(16'h5678);
    pulse_refresh();
    wait_cyc(30);
    rst_n = 1'b0;
    #1;
    chk("arst_we", bus.fb_we, 0);
    chk("arst_busy", bus.busy, 0);
    exp_q.delete();
    push_sweep(16'h5678);
    step();
    step();
    rst_n = 1'b1;
    wait_done();
    repeat (4) step();

    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.fb_we || bus.done) viol++;
    end
    chk("idle_quiet", viol, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
